// File: rtl/math_pkg.sv
// Shared floating-point helpers for the math stages: result class flags and
// a width-agnostic IEEE-754 classifier.
package math_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP64_EXP_W = 11;
  localparam int FP64_MAN_W = 52;

  typedef struct packed {
    logic nan;
    logic pinf;
    logic ninf;
    logic zero;
    logic subn;
  } fp_flags_t;

  // bits holds the operand right-aligned; fields beyond exp_w+man_w+1 are ignored.
  function automatic fp_flags_t fp_classify(input logic [63:0] bits,
                                            input int exp_w,
                                            input int man_w);
    fp_flags_t f;
    logic      e_ones;
    logic      e_zero;
    logic      m_zero;
    logic      sgn;
    e_ones = 1'b1;
    e_zero = 1'b1;
    m_zero = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i < man_w) begin
        m_zero = m_zero & ~bits[i];
      end else if (i < man_w + exp_w) begin
        e_ones = e_ones & bits[i];
        e_zero = e_zero & ~bits[i];
      end
    end
    sgn    = bits[man_w + exp_w];
    f      = '0;
    f.nan  = e_ones & ~m_zero;
    f.pinf = e_ones & m_zero & ~sgn;
    f.ninf = e_ones & m_zero & sgn;
    f.zero = e_zero & m_zero;
    f.subn = e_zero & ~m_zero;
    return f;
  endfunction

endpackage

// File: rtl/math_fp_classify.sv
// Combinational IEEE-754 classifier for binary32/binary64 operands.
module math_fp_classify
  import math_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] data_i,
  output fp_flags_t        flags_o
);

  localparam int EXP_W = (WIDTH == 64) ? FP64_EXP_W : FP32_EXP_W;
  localparam int MAN_W = (WIDTH == 64) ? FP64_MAN_W : FP32_MAN_W;

  logic [63:0] bits_ext;

  assign bits_ext = 64'(data_i);
  assign flags_o  = fp_classify(bits_ext, EXP_W, MAN_W);

endmodule

// File: rtl/math_fp_result_buffer.sv
// Two-entry registered skid FIFO behind the combinational math units; tags
// each beat with its FP class and accumulates sticky exception flags.
module math_fp_result_buffer
  import math_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [4:0]       out_flags_o,
  output logic [4:0]       sticky_flags_o,
  input  logic             sticky_clr_i
);

  if (WIDTH != 32 && WIDTH != 64) begin : g_width_check
    $fatal(1, "math_fp_result_buffer: WIDTH must be 32 or 64");
  end

  logic [WIDTH-1:0] data_q [2];
  fp_flags_t        flags_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  fp_flags_t        sticky_q, sticky_d;
  fp_flags_t        in_flags;
  logic             push, pop;

  math_fp_classify #(.WIDTH(WIDTH)) u_classify (
    .data_i  (in_data_i),
    .flags_o (in_flags)
  );

  // in_ready depends only on registered count, keeping out_ready off the upstream path
  assign in_ready_o     = rst_n_i && (count_q != 2'd2);
  assign out_valid_o    = (count_q != 2'd0);
  assign out_data_o     = data_q[rd_ptr_q];
  assign out_flags_o    = flags_q[rd_ptr_q];
  assign sticky_flags_o = sticky_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // a pop in the clear cycle still lands in the sticky register
    sticky_d = (sticky_clr_i ? fp_flags_t'('0) : sticky_q)
             | (pop ? flags_q[rd_ptr_q] : fp_flags_t'('0));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      sticky_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q]  <= in_data_i;
      flags_q[wr_ptr_q] <= in_flags;
    end
  end

endmodule

// File: tb/tb_math_fp_result_buffer.sv
// Directed bench for math_fp_result_buffer: binary32 and binary64 instances.
module tb_math_fp_result_buffer;

  localparam logic [4:0] F_NONE = 5'b00000;
  localparam logic [4:0] F_NAN  = 5'b10000;
  localparam logic [4:0] F_PINF = 5'b01000;
  localparam logic [4:0] F_NINF = 5'b00100;
  localparam logic [4:0] F_ZERO = 5'b00010;
  localparam logic [4:0] F_SUBN = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, sticky_clr;
  logic [31:0] in_data, out_data;
  logic [4:0]  out_flags, sticky;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, sticky_clr64;
  logic [63:0] in_data64, out_data64;
  logic [4:0]  out_flags64, sticky64;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  math_fp_result_buffer #(.WIDTH(32)) u_dut32 (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .out_flags_o    (out_flags),
    .sticky_flags_o (sticky),
    .sticky_clr_i   (sticky_clr)
  );

  math_fp_result_buffer #(.WIDTH(64)) u_dut64 (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .in_valid_i     (in_valid64),
    .in_ready_o     (in_ready64),
    .in_data_i      (in_data64),
    .out_valid_o    (out_valid64),
    .out_ready_i    (out_ready64),
    .out_data_o     (out_data64),
    .out_flags_o    (out_flags64),
    .sticky_flags_o (sticky64),
    .sticky_clr_i   (sticky_clr64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    logic in_v_r, out_r_r;
    logic [31:0] d_r;
    int sz;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sticky_clr = 1'b0;
    in_valid64 = 1'b0; in_data64 = '0; out_ready64 = 1'b0; sticky_clr64 = 1'b0;

    // 1. reset, then push 1.0
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sticky", sticky, 0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h3F80_0000; out_ready = 1'b1;
    @(negedge clk);
    chk("t1_in_ready_after_release", in_ready, 1);
    in_valid = 1'b0;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 32'h3F80_0000);
    chk("t1_out_flags", out_flags, F_NONE);
    chk("t1_sticky", sticky, 0);
    @(negedge clk);
    chk("t1_drained", out_valid, 0);

    // 2. fill with out_ready low, third beat held upstream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hFF80_0000;
    @(negedge clk);
    chk("t2_ready_cnt1", in_ready, 1);
    in_data = 32'h7FC0_0000;
    @(negedge clk);
    chk("t2_ready_full", in_ready, 0);
    in_data = 32'h0000_0001;
    @(negedge clk);
    chk("t2_hold_ready", in_ready, 0);
    chk("t2_hold_data", out_data, 32'hFF80_0000);
    chk("t2_hold_flags", out_flags, F_NINF);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t2_beat2_data", out_data, 32'h7FC0_0000);
    chk("t2_beat2_flags", out_flags, F_NAN);
    chk("t2_sticky1", sticky, F_NINF);
    chk("t2_ready_again", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t2_beat3_data", out_data, 32'h0000_0001);
    chk("t2_beat3_flags", out_flags, F_SUBN);
    chk("t2_sticky2", sticky, F_NINF | F_NAN);
    @(negedge clk);
    chk("t2_empty", out_valid, 0);
    chk("t2_sticky_all", sticky, 5'b10101);

    // 3a. 16-beat stream, one per cycle
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        chk("t3_stream_valid", out_valid, 1);
        chk("t3_stream_data", out_data, 64'(32'h3F80_0000 + 32'(i - 1)));
      end
      chk("t3_stream_ready", in_ready, 1);
      if (i < 16) begin
        in_valid = 1'b1; in_data = 32'h3F80_0000 + 32'(i);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("t3_stream_empty", out_valid, 0);

    // 3b. random handshakes against a queue model
    for (int c = 0; c < 80; c++) begin
      sz = exp_q.size();
      chk("t3r_valid", out_valid, (sz != 0));
      chk("t3r_ready", in_ready, (sz != 2));
      if (sz != 0) chk("t3r_data", out_data, exp_q[0]);
      in_v_r  = 1'($urandom_range(0, 1));
      out_r_r = 1'($urandom_range(0, 1));
      d_r     = {1'b0, 8'h80, 23'($urandom)};
      in_valid = in_v_r; out_ready = out_r_r; in_data = d_r;
      if (sz != 0 && out_r_r) void'(exp_q.pop_front());
      if (sz != 2 && in_v_r) exp_q.push_back(d_r);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3r_drained", out_valid, 0);
    chk("t3r_sticky_kept", sticky, 5'b10101);

    // 4. clear coincident with a pop of -0.0
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h8000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t4_flags", out_flags, F_ZERO);
    out_ready = 1'b1; sticky_clr = 1'b1;
    @(negedge clk);
    chk("t4_sticky_clr_pop", sticky, F_ZERO);
    out_ready = 1'b0;
    @(negedge clk);
    chk("t4_sticky_clr_only", sticky, 0);
    sticky_clr = 1'b0;

    // 5. reset while full
    in_valid = 1'b1; in_data = 32'h7F80_0000;
    @(negedge clk);
    in_data = 32'h7FC0_0001;
    @(negedge clk);
    chk("t5_full", in_ready, 0);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_ready", in_ready, 0);
    chk("t5_rst_sticky", sticky, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h4000_0000;
    @(negedge clk);
    in_data = 32'h4040_0000;
    chk("t5_first_data", out_data, 32'h4000_0000);
    chk("t5_first_valid", out_valid, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t5_second_data", out_data, 32'h4040_0000);

    // 6. binary64 classification
    out_ready64 = 1'b1;
    in_valid64 = 1'b1; in_data64 = 64'h7FF0_0000_0000_0000;
    @(negedge clk);
    chk("t6_pinf_data", out_data64, 64'h7FF0_0000_0000_0000);
    chk("t6_pinf_flags", out_flags64, F_PINF);
    in_data64 = 64'h0000_0000_0000_0000;
    @(negedge clk);
    chk("t6_zero_flags", out_flags64, F_ZERO);
    in_data64 = 64'h3FF0_0000_0000_0000;
    @(negedge clk);
    in_valid64 = 1'b0;
    chk("t6_one_flags", out_flags64, F_NONE);
    chk("t6_one_valid", out_valid64, 1);
    @(negedge clk);
    chk("t6_sticky", sticky64, F_PINF | F_ZERO);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
